// File: rtl/speed_scheduler.sv
// rtl/speed_scheduler.sv - run-state controller and level/period scheduler for the game-tick timer
// Every output is a register; the next-state logic decides pulses one cycle ahead.
module speed_scheduler #(
    parameter int INIT_PERIOD     = 500,
    parameter int MIN_PERIOD      = 100,
    parameter int PERIOD_STEP     = 50,
    parameter int STEPS_PER_LEVEL = 16,
    parameter int MAX_LEVEL       = 15
) (
    input  logic       Clk_i,
    input  logic       Rst_i,
    input  logic       Start_i,
    input  logic       Pause_i,
    input  logic       Stop_i,
    input  logic       Tick_i,
    output logic       TmrEnable_o,
    output logic       TmrClear_o,
    output logic [9:0] TmrCfg_o,
    output logic       Step_o,
    output logic       LevelUp_o,
    output logic [3:0] Level_o,
    output logic [1:0] State_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_PAUSED = 2'b10,
        S_OVER   = 2'b11
    } state_e;

    localparam logic [9:0]  INIT_CFG   = 10'(INIT_PERIOD);
    localparam logic [9:0]  MIN_CFG    = 10'(MIN_PERIOD);
    localparam logic [9:0]  STEP_CFG   = 10'(PERIOD_STEP);
    localparam logic [9:0]  LAST_CNT   = 10'(STEPS_PER_LEVEL - 1);
    localparam logic [3:0]  TOP_LEVEL  = 4'(MAX_LEVEL);
    localparam logic [10:0] SAT_THRESH = 11'(MIN_PERIOD + PERIOD_STEP);

    state_e     state_q, state_d;
    logic [9:0] cfg_q, cfg_d;
    logic [3:0] level_q, level_d;
    logic [9:0] cnt_q, cnt_d;
    logic       en_q, en_d;
    logic       clr_q, clr_d;
    logic       step_q, step_d;
    logic       lvup_q, lvup_d;
    logic [9:0] next_period;

    // Below the threshold the subtraction would undershoot the floor, so clamp instead.
    always_comb begin
        if ({1'b0, cfg_q} < SAT_THRESH) begin
            next_period = MIN_CFG;
        end else begin
            next_period = cfg_q - STEP_CFG;
        end
    end

    always_comb begin
        state_d = state_q;
        cfg_d   = cfg_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        clr_d   = 1'b0;
        step_d  = 1'b0;
        lvup_d  = 1'b0;
        case (state_q)
            S_IDLE, S_OVER: begin
                if (Start_i) begin
                    state_d = S_RUN;
                    cfg_d   = INIT_CFG;
                    level_d = 4'd0;
                    cnt_d   = 10'd0;
                    clr_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (Stop_i) begin
                    state_d = S_OVER;
                end else if (Pause_i) begin
                    state_d = S_PAUSED;
                end else if (Tick_i) begin
                    step_d = 1'b1;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d = 10'd0;
                        if (level_q < TOP_LEVEL) begin
                            level_d = level_q + 4'd1;
                            lvup_d  = 1'b1;
                            clr_d   = 1'b1;
                            cfg_d   = next_period;
                        end
                    end else begin
                        cnt_d = cnt_q + 10'd1;
                    end
                end
            end
            S_PAUSED: begin
                if (Stop_i) begin
                    state_d = S_OVER;
                end else if (Pause_i) begin
                    state_d = S_RUN;
                end
            end
            default: state_d = S_IDLE;
        endcase
        en_d = (state_d == S_RUN);
    end

    always_ff @(posedge Clk_i or posedge Rst_i) begin
        if (Rst_i) begin
            state_q <= S_IDLE;
            cfg_q   <= INIT_CFG;
            level_q <= 4'd0;
            cnt_q   <= 10'd0;
            en_q    <= 1'b0;
            clr_q   <= 1'b0;
            step_q  <= 1'b0;
            lvup_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cfg_q   <= cfg_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            en_q    <= en_d;
            clr_q   <= clr_d;
            step_q  <= step_d;
            lvup_q  <= lvup_d;
        end
    end

    assign TmrEnable_o = en_q;
    assign TmrClear_o  = clr_q;
    assign TmrCfg_o    = cfg_q;
    assign Step_o      = step_q;
    assign LevelUp_o   = lvup_q;
    assign Level_o     = level_q;
    assign State_o     = state_q;

endmodule

// File: doc/speed_scheduler.md
# speed_scheduler

Run-state controller and difficulty scheduler for the configurable game-tick timer. It enables, clears and programs the timer's 10-bit period, turns each timer tick into a one-cycle game step, and shortens the period every fixed number of steps to raise the level. It sits between the game-control inputs (start/pause/stop) and the timer, and feeds `Step` and `Level` to the game logic and display.

## Interface
Parameters:
- `INIT_PERIOD`, 500: period programmed at game start, in timer units (ms). Legal range `MIN_PERIOD..1023`.
- `MIN_PERIOD`, 100: saturation floor for the period. Must be ≥1.
- `PERIOD_STEP`, 50: period decrement applied per level-up. Legal range 1..1023.
- `STEPS_PER_LEVEL`, 16: steps per level. Legal range 1..1024.
- `MAX_LEVEL`, 15: highest level. Legal range 0..15.

Ports:
- `Clk`  in  1  system clock; every register updates on its rising edge.
- `Rst`  in  1  reset, asynchronous and active-high.
- `Start`  in  1  one-cycle pulse: begin a new game.
- `Pause`  in  1  one-cycle pulse: toggle between RUN and PAUSED.
- `Stop`  in  1  one-cycle pulse: game over.
- `Tick`  in  1  one-cycle pulse from the timer.
- `TmrEnable`  out  1  timer enable.
- `TmrClear`  out  1  one-cycle timer count clear.
- `TmrCfg`  out  10  timer period.
- `Step`  out  1  one-cycle game-advance pulse.
- `LevelUp`  out  1  one-cycle pulse on a level increment.
- `Level`  out  4  current level.
- `State`  out  2  IDLE=00, RUN=01, PAUSED=10, OVER=11.

## Operation
- **All outputs are registered.** Reset values:
  - `State`=IDLE
  - `TmrCfg`=INIT_PERIOD
  - `TmrEnable`, `TmrClear`, `Step`, `LevelUp` = 0
  - `Level`=0
  - internal `StepCnt` (10-bit) = 0
- **IDLE:** `TmrEnable`=0; `Tick` is ignored. `Start` → RUN, and on the same edge:
  - `TmrCfg`=INIT_PERIOD
  - `Level`=0
  - `StepCnt`=0
  - `TmrClear`=1
- **RUN:** `TmrEnable`=1. On `Tick`:
  - `Step`=1.
  - If `StepCnt`=STEPS_PER_LEVEL-1 and `Level`<MAX_LEVEL:
    - `StepCnt`=0
    - `Level`+1
    - `LevelUp`=1
    - `TmrClear`=1
    - `TmrCfg` = max(`TmrCfg`−PERIOD_STEP, MIN_PERIOD)
  - If `StepCnt`=STEPS_PER_LEVEL-1 and `Level`=MAX_LEVEL: `StepCnt` wraps to 0 and nothing else changes.
  - Otherwise `StepCnt`+1.
- **RUN, Pause:** → PAUSED.
- **PAUSED:**
  - `TmrEnable`=0; `Tick` is ignored.
  - `StepCnt`, `Level` and `TmrCfg` are held.
  - `Pause` → RUN with no clear; the timer resumes its partial count.
- **Stop:** from RUN or PAUSED → OVER. `Level` and `TmrCfg` are held. `TmrEnable`=0.
- **OVER:** `Start` performs the same re-initialisation as from IDLE and enters RUN directly.
- **Ignored inputs:** `Start` in RUN or PAUSED; `Pause` in IDLE or OVER; `Stop` in IDLE or OVER.
- **Simultaneous-input priority:** Stop > Pause > Tick.
  - A `Tick` coincident with `Stop` or `Pause` in RUN produces no `Step` and no count.
  - `Start` is only legal in IDLE or OVER, so it never competes with them.
- **Period arithmetic:** the subtraction is 11-bit, so no wrap. If `TmrCfg` < MIN_PERIOD+PERIOD_STEP, the result is MIN_PERIOD. Once at MIN_PERIOD, further level-ups keep MIN_PERIOD but still increment `Level`.

## Timing
- **Step latency:** `Tick` high at edge N → `Step` high for exactly cycle N+1.
- **Level-up outputs:** `LevelUp`, `TmrClear`, the new `TmrCfg` and the new `Level` all update at that same edge.
- **Start:** `Start` sampled at edge N → at N+1, `State`=RUN, `TmrEnable`=1 and `TmrClear`=1, for one cycle.
- **Pause/Stop:** `TmrEnable` drops at the edge that samples the input.
- **Pulse width:** `Step`, `LevelUp` and `TmrClear` are never high for two consecutive cycles unless driven by consecutive qualifying events.
- **Reset:** `Rst` asserted at any time forces all reset values immediately, without waiting for `Clk`. On release, the block is in IDLE with no pulse pending.
- **Input contract:** inputs are synchronous to `Clk`. `Tick` pulses are ≥2 cycles apart.

## Test plan
1. **Start and step count.** Reset, then `Start`.
   - Next cycle: `State`=01, `TmrEnable`=1, `TmrClear`=1 for one cycle, `TmrCfg`=500.
   - Each of 15 `Tick`s gives one `Step` one cycle later; `Level` stays 0.
2. **Level-up and saturation.** From test 1, issue a 16th `Tick`.
   - `Step`, `LevelUp` and `TmrClear` all =1; `Level`=1; `TmrCfg`=450.
   - Continue to 144 ticks: `Level`=9 and `TmrCfg`=100 stay there.
   - The 160th tick gives `Level`=10 with `TmrCfg` still 100.
3. **Pause behaviour.** In RUN at `StepCnt`=5, pulse `Pause`.
   - `TmrEnable`=0 and `State`=10. Three `Tick`s produce no `Step`.
   - `Pause` again: `State`=01, `TmrEnable`=1, no `TmrClear`. 11 further ticks produce a level-up.
4. **Simultaneous inputs.**
   - `Tick` and `Stop` on the same cycle: `State`=11, no `Step`, `Level`/`TmrCfg` held.
   - Then `Start`: `State`=01, `Level`=0, `TmrCfg`=500, `TmrClear`=1.
5. **Max level.** With MAX_LEVEL=2 and STEPS_PER_LEVEL=1:
   - Ticks 1 and 2 give `LevelUp`, ending at `Level`=2 and `TmrCfg`=400.
   - Ticks 3 and beyond give `Step` only, with no `LevelUp` or `TmrClear`.
6. **Asynchronous reset.** Assert `Rst` mid-cycle while in PAUSED at level 3.
   - Without any `Clk` edge: `State`=00, `Level`=0, `TmrCfg`=500, `TmrEnable`=0.
   - `Start` and `Tick` are ignored while `Rst`=1.
